opb_err_cnt_bank: RTL and testbench
===================================

// Module: opb_err_cnt_bank
// PURPOSE
//  Multi-channel error-counter bank with a built-in OPB slave port.
//  Counts single-cycle error strobes from datapath checkers and exposes each count to the PPC as a read-only OPB word.
//  Per-channel clear, global clear, freeze and sticky overflow are software controlled.
//  Replaces one single-register OPB slave per checker with one parametrised block.
//  Error sources must already be synchronous to OPB_Clk.
// PARAMETERS
//  C_BASEADDR   32'h01008900  first byte address of the block; aligned to its span
//  C_HIGHADDR   32'h010089FF  last byte address; span must be >= 4*(N_CH+1)
//  C_OPB_AWIDTH 32            OPB address width
//  C_OPB_DWIDTH 32            OPB data width; only 32 is supported
//  N_CH         8             number of counter channels, 1..63
//  CNT_W        16            counter width, 1..31
//  SATURATE     1             1: hold at all-ones; 0: wrap to 0
// PORTS
//  OPB_Clk      in   1       sole clock
//  OPB_Rst      in   1       synchronous, active-high reset
//  OPB_ABus     in   [0:31]  byte address; bit 0 is the MSB
//  OPB_BE       in   [0:3]   byte enables; ignored (whole-word access only)
//  OPB_DBus     in   [0:31]  write data
//  OPB_RNW      in   1       1 = read, 0 = write
//  OPB_select   in   1       transfer qualifier
//  OPB_seqAddr  in   1       ignored
//  Sl_DBus      out  [0:31]  read data; zero except during a read ack
//  Sl_xferAck   out  1       one-cycle transfer acknowledge
//  Sl_errAck    out  1       tied 0
//  Sl_retry     out  1       tied 0
//  Sl_toutSup   out  1       tied 0
//  err_in       in   [N_CH-1:0]  per-channel error strobe; +1 per high cycle
// BEHAVIOUR
//  Reset (OPB_Rst high at an edge): counters, overflow flags, freeze, Sl_xferAck and Sl_DBus all go to 0.
//   - err_in is ignored while reset is high.
//  Word map (word k is at C_BASEADDR+4k):
//   - k=0: CTRL.
//   - k=1..N_CH: counter for channel k-1.
//   - Other offsets inside the span ack normally: read returns 0, write has no effect.
//  Bit numbering: values are right-aligned, so value LSB = bus bit 31.
//  Address hit: OPB_select high and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
//  Handshake:
//   - At an edge where hit & ~Sl_xferAck holds, Sl_xferAck is set for exactly one cycle.
//   - Ack latency is 1 cycle after select.
//   - No back-to-back acks: a held select gets a new ack every 2nd cycle.
//  Read data:
//   - Registered at the same edge that sets the ack, and valid only in the ack cycle.
//   - Reflects the state before that edge's own update.
//   - Counter word: bit 0 = sticky overflow flag; count right-aligned; unused bits 0.
//   - CTRL word: bit 30 = freeze; all other bits 0.
//  Writes take effect at the edge that sets the ack:
//   - CTRL bit 31 = 1: clear all counters and flags (self-clearing, never stored).
//   - CTRL bit 30: loaded into freeze.
//   - Any write to a counter word clears that channel's count and its overflow flag.
//  Counting, per channel, per edge:
//   - Increment when err_in=1, freeze=0, and no clear is active on that channel.
//   - Clear beats increment in the same cycle: the result is 0 and the strobe is lost.
//  Increment at all-ones:
//   - SATURATE=1: count holds; overflow flag is set.
//   - SATURATE=0: count wraps to 0; overflow flag is set.
//  Overflow flag: stays set until that channel is cleared or a global clear occurs.
//  Freeze=1: counts and flags hold, reads still work, and strobes are discarded (not queued).
//  Reset while a transfer is in progress: ack is dropped and no write is applied; the master times out and retries.
// STRUCTURE
//  Package opb_err_cnt_pkg holds:
//   - CTRL word offset, CTRL bit positions (CLR=31, FRZ=30) and overflow bit (0).
//   - An address-decode function returning the word index.
//  Sub-module err_cnt_chan (params CNT_W, SATURATE):
//   - Inputs: clk, rst, inc, clr. Outputs: cnt, ovf.
//   - Instantiated N_CH times in a generate loop.
//  The top level holds OPB decode, ack and read mux registers, and the freeze bit.
// TESTING
//  1. Reset, then read all words -> every read returns 0; each ack is exactly 1 cycle wide.
//  2. Pulse err_in[3] for 5 cycles, then read word 4 -> 0x00000005; other channels read 0.
//  3. CNT_W=4, SATURATE=1: 20 pulses on ch0 -> 0x8000000F.
//     Same with SATURATE=0 -> 0x80000004.
//  4. Write any value to word 1 while err_in[0]=1 in that cycle -> ch0 reads 0 and its flag is clear.
//  5. Write CTRL=0x2, pulse ch2 ten times, then write CTRL=0x0 -> ch2 unchanged; a CTRL read during freeze returns 0x2.
//  6. Write CTRL=0x1 with counters nonzero -> all words read 0.
//     An address outside the span gets no ack.
//     Select held 4 cycles -> acks in cycles 2 and 4 only.

Source files
------------

// File: rtl/opb_err_cnt_pkg.sv
// Shared constants and helpers for the OPB error-counter bank.
// Bus bit positions use OPB numbering (bit 0 = MSB).
package opb_err_cnt_pkg;

    localparam int unsigned CTRL_WORD    = 0;
    localparam int unsigned CTRL_CLR_BIT = 31;
    localparam int unsigned CTRL_FRZ_BIT = 30;
    localparam int unsigned CNT_OVF_BIT  = 0;
    localparam int unsigned WIDX_W       = 30;

    typedef logic [WIDX_W-1:0] widx_t;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_e;

    function automatic widx_t word_index(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return widx_t'(off >> 2);
    endfunction

    // Counter word layout: sticky overflow in bus bit 0, count right-aligned.
    function automatic logic [0:31] cnt_word(input logic ovf, input logic [30:0] cnt);
        logic [0:31] w;
        w              = 32'h0000_0000;
        w[1:31]        = cnt;
        w[CNT_OVF_BIT] = ovf;
        return w;
    endfunction

endpackage

// File: rtl/opb_err_cnt_bank_chan.sv
// One error-counter channel: saturating or wrapping count plus sticky overflow.
module err_cnt_chan #(
    parameter int unsigned CNT_W    = 16,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             ovf_d, ovf_q;

    // Next-state: clear wins over increment, so a strobe in a clear cycle is lost.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
                cnt_d = SATURATE ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
            ovf_d = ovf_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/opb_err_cnt_bank.sv
// OPB slave exposing N_CH error counters plus a CTRL word (freeze / global clear).
module opb_err_cnt_bank
    import opb_err_cnt_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_8900,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_89FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter int unsigned N_CH         = 8,
    parameter int unsigned CNT_W        = 16,
    parameter bit          SATURATE     = 1'b1
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [N_CH-1:0]         err_in
);

    logic        hit_s, start_s, rd_s, wr_s, gclr_s, is_ctrl_s;
    acc_e        acc_s;
    widx_t       widx_s;
    logic [0:31] rd_word_s;
    logic [0:31] chan_word_s [N_CH];
    logic [N_CH-1:0] clr_s, inc_s, ovf_s;
    logic [CNT_W-1:0] cnt_s [N_CH];

    logic        ack_d, ack_q;
    logic        frz_d, frz_q;
    logic [0:31] rdata_d, rdata_q;
    logic        unused_s;

    assign unused_s  = ^{OPB_BE, OPB_seqAddr};
    assign widx_s    = word_index(OPB_ABus, C_BASEADDR);
    assign is_ctrl_s = (widx_s == widx_t'(CTRL_WORD));

    // Address hit and access classification; a new transfer starts only when no ack is pending.
    always_comb begin
        hit_s   = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
        start_s = hit_s && !ack_q;
        if (!start_s) begin
            acc_s = ACC_NONE;
        end else if (OPB_RNW) begin
            acc_s = ACC_READ;
        end else begin
            acc_s = ACC_WRITE;
        end
        case (acc_s)
            ACC_READ:  begin rd_s = 1'b1; wr_s = 1'b0; end
            ACC_WRITE: begin rd_s = 1'b0; wr_s = 1'b1; end
            default:   begin rd_s = 1'b0; wr_s = 1'b0; end
        endcase
        gclr_s = wr_s && is_ctrl_s && OPB_DBus[CTRL_CLR_BIT];
    end

    // Read mux; unmapped words inside the span read as zero.
    always_comb begin
        rd_word_s = 32'h0000_0000;
        if (is_ctrl_s) begin
            rd_word_s[CTRL_FRZ_BIT] = frz_q;
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                rd_word_s = rd_word_s | ((widx_s == widx_t'(i + 1)) ? chan_word_s[i] : 32'h0000_0000);
            end
        end
    end

    // Next-state for ack, read data and freeze.
    always_comb begin
        ack_d = start_s;
        if (rd_s) begin
            rdata_d = rd_word_s;
        end else begin
            rdata_d = 32'h0000_0000;
        end
        if (wr_s && is_ctrl_s) begin
            frz_d = OPB_DBus[CTRL_FRZ_BIT];
        end else begin
            frz_d = frz_q;
        end
    end

    // Slave registers with synchronous reset.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            ack_q   <= 1'b0;
            frz_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            ack_q   <= ack_d;
            frz_q   <= frz_d;
            rdata_q <= rdata_d;
        end
    end

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_chan
        assign clr_s[g] = gclr_s || (wr_s && (widx_s == widx_t'(g + 1)));
        assign inc_s[g] = err_in[g] && !frz_q;

        err_cnt_chan #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_chan (
            .clk (OPB_Clk),
            .rst (OPB_Rst),
            .inc (inc_s[g]),
            .clr (clr_s[g]),
            .cnt (cnt_s[g]),
            .ovf (ovf_s[g])
        );

        assign chan_word_s[g] = cnt_word(ovf_s[g], 31'(cnt_s[g]));
    end

    assign Sl_DBus    = rdata_q;
    assign Sl_xferAck = ack_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_err_cnt_bank.sv
// Bench for opb_err_cnt_bank: three instances (wide saturating, narrow saturating, narrow wrapping)
// share one OPB bus and are compared every cycle against a behavioural model.
module tb_opb_err_cnt_bank;

    localparam logic [31:0] BASE = 32'h0100_8900;
    localparam logic [31:0] HIGH = 32'h0100_89FF;
    localparam int ND = 3;
    localparam int unsigned NCH [ND] = '{8, 2, 2};
    localparam int unsigned WB  [ND] = '{16, 4, 4};
    localparam bit          SAT [ND] = '{1'b1, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:31] abus = '0;
    logic [0:3]  be = 4'hF;
    logic [0:31] dbus = '0;
    logic        rnw = 1'b1, sel = 1'b0, seqa = 1'b0;
    logic [7:0]  err = 8'h00;

    logic [0:31] rd_o    [ND];
    logic        ack_o   [ND];
    logic        eack_o  [ND];
    logic        retry_o [ND];
    logic        tout_o  [ND];

    always #5 clk = ~clk;

    opb_err_cnt_bank #(.C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
                       .N_CH(8), .CNT_W(16), .SATURATE(1'b1)) u_dut0 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqa), .Sl_DBus(rd_o[0]),
        .Sl_xferAck(ack_o[0]), .Sl_errAck(eack_o[0]), .Sl_retry(retry_o[0]),
        .Sl_toutSup(tout_o[0]), .err_in(err));

    opb_err_cnt_bank #(.C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
                       .N_CH(2), .CNT_W(4), .SATURATE(1'b1)) u_dut1 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqa), .Sl_DBus(rd_o[1]),
        .Sl_xferAck(ack_o[1]), .Sl_errAck(eack_o[1]), .Sl_retry(retry_o[1]),
        .Sl_toutSup(tout_o[1]), .err_in(err[1:0]));

    opb_err_cnt_bank #(.C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
                       .N_CH(2), .CNT_W(4), .SATURATE(1'b0)) u_dut2 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqa), .Sl_DBus(rd_o[2]),
        .Sl_xferAck(ack_o[2]), .Sl_errAck(eack_o[2]), .Sl_retry(retry_o[2]),
        .Sl_toutSup(tout_o[2]), .err_in(err[1:0]));

    int nvec  = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    // Behavioural model: counts as integers, words built from the documented layout.
    int unsigned cnt_m [ND][8];
    bit          ovf_m [ND][8];
    bit          frz_m [ND];
    bit          ack_m = 1'b0;
    logic [31:0] rd_m  [ND];
    logic [31:0] cap   [ND];

    initial begin
        for (int d = 0; d < ND; d++) begin
            rd_m[d]  = 32'h0;
            frz_m[d] = 1'b0;
            for (int c = 0; c < 8; c++) begin
                cnt_m[d][c] = 0;
                ovf_m[d][c] = 1'b0;
            end
        end
    end

    function automatic logic [31:0] model_word(input int d, input int unsigned k);
        if (k == 0) return {30'd0, frz_m[d], 1'b0};
        else if (k <= NCH[d]) return {ovf_m[d][k-1], 31'(cnt_m[d][k-1])};
        else return 32'h0;
    endfunction

    always @(posedge clk) begin
        logic [31:0] a, wd;
        int unsigned k, mx;
        bit start, wr, clr;
        a     = abus;
        wd    = dbus;
        start = !rst && sel && (a >= BASE) && (a <= HIGH) && !ack_m;
        wr    = start && !rnw;
        k     = (a - BASE) >> 2;
        for (int d = 0; d < ND; d++) begin
            rd_m[d] <= (start && rnw) ? model_word(d, k) : 32'h0;
            mx = (32'd1 << WB[d]) - 1;
            for (int c = 0; c < int'(NCH[d]); c++) begin
                clr = wr && ((k == 0 && wd[0]) || (k == c + 1));
                if (rst || clr) begin
                    cnt_m[d][c] <= 0;
                    ovf_m[d][c] <= 1'b0;
                end else if (err[c] && !frz_m[d]) begin
                    if (cnt_m[d][c] == mx) begin
                        ovf_m[d][c] <= 1'b1;
                        cnt_m[d][c] <= SAT[d] ? mx : 0;
                    end else begin
                        cnt_m[d][c] <= cnt_m[d][c] + 1;
                    end
                end
            end
            if (rst) frz_m[d] <= 1'b0;
            else if (wr && k == 0) frz_m[d] <= wd[1];
        end
        ack_m <= start;
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        logic [31:0] v;
        if (chk_en) begin
            for (int d = 0; d < ND; d++) begin
                v = rd_o[d];
                nvec++;
                if (ack_o[d] !== ack_m) begin
                    nfail++;
                    $display("FAIL ack dut%0d t=%0t got=%b required=%b", d, $time, ack_o[d], ack_m);
                end
                nvec++;
                if (v !== rd_m[d]) begin
                    nfail++;
                    $display("FAIL dbus dut%0d t=%0t got=%h required=%h", d, $time, v, rd_m[d]);
                end
                nvec++;
                if ({eack_o[d], retry_o[d], tout_o[d]} !== 3'b000) begin
                    nfail++;
                    $display("FAIL tieoff dut%0d got=%b required=000", d, {eack_o[d], retry_o[d], tout_o[d]});
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] addr, input bit rd, input logic [31:0] wd);
        int n;
        abus = addr; rnw = rd; dbus = wd; sel = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack_o[0] !== 1'b1 && n < 8);
        nvec++;
        if (ack_o[0] !== 1'b1) begin
            nfail++;
            $display("FAIL xfer_timeout addr=%h got=%b required=1", addr, ack_o[0]);
        end
        for (int d = 0; d < ND; d++) cap[d] = rd_o[d];
        @(posedge clk);
        #1;
        sel = 1'b0; rnw = 1'b1; dbus = '0;
    endtask

    initial begin
        bit [3:0] pat;
        int acks;
        rst = 1'b1;
        cyc(1);
        chk_en = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);

        for (int k = 0; k < 10; k++) begin
            xfer(BASE + 32'(4 * k), 1'b1, 32'h0);
            expect_lit("reset_read", cap[0], 32'h0);
        end

        err[3] = 1'b1; cyc(5); err[3] = 1'b0;
        xfer(BASE + 32'd16, 1'b1, 32'h0);
        expect_lit("ch3_five", cap[0], 32'h0000_0005);
        xfer(BASE + 32'd12, 1'b1, 32'h0);
        expect_lit("ch2_zero", cap[0], 32'h0);

        err[0] = 1'b1; cyc(20); err[0] = 1'b0;
        xfer(BASE + 32'd4, 1'b1, 32'h0);
        expect_lit("ch0_wide", cap[0], 32'h0000_0014);
        expect_lit("ch0_sat", cap[1], 32'h8000_000F);
        expect_lit("ch0_wrap", cap[2], 32'h8000_0004);

        abus = BASE + 32'd4; rnw = 1'b0; dbus = 32'hDEAD_BEEF; sel = 1'b1; err[0] = 1'b1;
        cyc(1);
        err[0] = 1'b0; sel = 1'b0; rnw = 1'b1; dbus = '0;
        cyc(1);
        xfer(BASE + 32'd4, 1'b1, 32'h0);
        for (int d = 0; d < ND; d++) expect_lit("clr_beats_inc", cap[d], 32'h0);

        err[2] = 1'b1; cyc(3); err[2] = 1'b0;
        xfer(BASE, 1'b0, 32'h2);
        err[2] = 1'b1; cyc(10); err[2] = 1'b0;
        xfer(BASE, 1'b1, 32'h0);
        expect_lit("ctrl_frozen", cap[0], 32'h0000_0002);
        xfer(BASE, 1'b0, 32'h0);
        xfer(BASE + 32'd12, 1'b1, 32'h0);
        expect_lit("ch2_held", cap[0], 32'h0000_0003);

        xfer(BASE, 1'b0, 32'h1);
        xfer(BASE + 32'd12, 1'b1, 32'h0);
        expect_lit("gclr_ch2", cap[0], 32'h0);
        xfer(BASE + 32'd16, 1'b1, 32'h0);
        expect_lit("gclr_ch3", cap[0], 32'h0);
        xfer(BASE, 1'b1, 32'h0);
        expect_lit("ctrl_after_clr", cap[0], 32'h0);

        acks = 0;
        abus = HIGH + 32'd1; rnw = 1'b1; sel = 1'b1;
        repeat (4) begin @(negedge clk); acks += int'(ack_o[0]); end
        abus = BASE - 32'd4;
        repeat (4) begin @(negedge clk); acks += int'(ack_o[0]); end
        @(posedge clk); #1; sel = 1'b0;
        expect_lit("out_of_span_acks", 32'(acks), 32'h0);

        abus = BASE; rnw = 1'b1; sel = 1'b1;
        for (int i = 0; i < 4; i++) begin @(negedge clk); pat[i] = ack_o[0]; end
        @(posedge clk); #1; sel = 1'b0;
        expect_lit("held_select", {28'h0, pat}, 32'h0000_000A);
        cyc(2);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            err = 8'($urandom);
            sel = ($urandom_range(0, 3) != 0);
            rnw = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 9))
                0:       abus = BASE + 32'($urandom_range(0, 255));
                1:       abus = HIGH + 32'($urandom_range(1, 64));
                default: abus = BASE + 32'(4 * $urandom_range(0, 12));
            endcase
            dbus = ($urandom & 32'hFFFF_FFFE) | 32'($urandom_range(0, 15) == 0);
            cyc(1);
        end
        rst = 1'b0; sel = 1'b0; err = 8'h00;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
